apb_fifo_bridge: RTL and testbench
==================================

# apb_fifo_bridge

APB3 slave that gives the CPU a register window onto the I2C core's TX and RX byte FIFOs. It is the parametrised successor of the plain APB/FIFO shim, adding:
- generic data and address widths;
- PREADY wait states while a FIFO is full or empty, bounded by a timeout that ends in PSLVERR;
- status/control registers with sticky error flags and an optional interrupt.

It sits between the APB interconnect and the TX/RX FIFOs in front of the I2C master.

## Interface
Parameters:
- DATA_W, 8: data width of PWDATA, PRDATA, APB_TX and APB_RX.
- ADDR_W, 8: PADDR width; the low 5 bits are decoded and the upper bits must be 0.
- WAIT_MAX, 15: maximum wait-state cycles on a blocked FIFO access before an error response; 0 means an immediate error.

Ports:
- PCLK  in  1  clock; all logic on posedge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSELx  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PREADY  out  1  transfer completes at this posedge.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1, 0 otherwise.
- W_ENA  out  1  TX FIFO write strobe.
- APB_TX  out  DATA_W  TX FIFO write data; equals PWDATA while W_ENA=1, 0 otherwise.
- WRITE_FULL  in  1  TX FIFO full.
- R_ENA  out  1  RX FIFO read strobe.
- APB_RX  in  DATA_W  RX FIFO data; valid one cycle after R_ENA.
- READ_EMPTY  in  1  RX FIFO empty.
- IRQ  out  1  interrupt, active high; present only with APB_BRIDGE_IRQ_EN.

## Operation
Register map:
- 0x00 TXDATA: write-only.
- 0x04 RXDATA: read-only.
- 0x08 STATUS: read; write-1-to-clear for bits 3:2.
  - bit 0: tx_full (live).
  - bit 1: rx_empty (live).
  - bit 2: tx_ovf (sticky).
  - bit 3: rx_udf (sticky).
- 0x0C CTRL: read/write; reset value 0x01.
  - bit 0: en.
  - bits 3:1: irq masks (rx_avail, tx_space, err).

FSM states: IDLE, ACCESS, RDLAT.
- IDLE → ACCESS on PSELx=1 with PENABLE=0 (setup phase). The wait counter clears.
- ACCESS, TXDATA write, en=1:
  - If WRITE_FULL=0: W_ENA=1 and PREADY=1 in the same cycle, then → IDLE.
  - Otherwise the counter increments each cycle. When the counter equals WAIT_MAX: PREADY=1, PSLVERR=1, no write, tx_ovf set, then → IDLE.
- ACCESS, RXDATA read, en=1:
  - If READ_EMPTY=0: R_ENA=1 for exactly one cycle, then → RDLAT.
  - If empty: same timeout rule as TXDATA; the timeout sets rx_udf and returns PRDATA=0.
- RDLAT: PREADY=1, PRDATA=APB_RX, PSLVERR=0, then → IDLE.
- STATUS and CTRL: zero wait states, PREADY=1 in the first ACCESS cycle.
- Immediate error (PREADY=1, PSLVERR=1 in the first ACCESS cycle, no FIFO strobe, no register change) for any of:
  - an unmapped address or nonzero upper address bits;
  - a write to RXDATA;
  - a read of TXDATA;
  - a TXDATA or RXDATA access while en=0.
- PSELx dropping during ACCESS (protocol violation): → IDLE with no strobe; any sticky flag set in that same cycle still applies.
- A sticky flag set and a W1C of that flag in the same cycle: set wins.
- PRDATA, PREADY, PSLVERR and the strobes are combinational from state and inputs. State, counter, CTRL and sticky flags are flops.

## Timing
- Reset (asynchronous):
  - FSM → IDLE; counter = 0; CTRL = 0x01; tx_ovf = rx_udf = 0.
  - Outputs: PREADY=0, PSLVERR=0, PRDATA=0, W_ENA=0, R_ENA=0, APB_TX=0, IRQ=0.
  - Reset asserted mid-wait aborts the transfer; the FIFOs see no strobe.
- Latency measured from the first PENABLE=1 cycle:
  - TXDATA not full: 0 wait states.
  - RXDATA not empty: 1 wait state.
  - Blocked access: exactly WAIT_MAX wait states, then the error cycle.
- A FIFO that becomes not-full or not-empty during the wait completes the access normally at that cycle.
- W_ENA and R_ENA never exceed one cycle per APB transfer.
- The counter is $clog2(WAIT_MAX+1) bits wide, minimum 1. It saturates and never wraps.

## Configuration
- APB_BRIDGE_IRQ_EN defined:
  - IRQ is a flop, set to (m_rx & !READ_EMPTY) | (m_tx & !WRITE_FULL) | (m_err & (tx_ovf | rx_udf)).
  - IRQ is updated every cycle and lags its sources by 1 cycle.
- Undefined:
  - IRQ port is removed.
  - CTRL[3:1] read 0 and ignore writes.

## Structure
- Package apb_fifo_bridge_pkg holds:
  - register offset localparams: ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS, ADDR_CTRL;
  - STATUS/CTRL bit index constants;
  - the state enum (IDLE, ACCESS, RDLAT).
- One sub-module, apb_wait_timer: saturating counter with clear/increment and a done=(count==WAIT_MAX) output, reusable by other slaves.

## Test plan
- Write 0xA5 to 0x00 with WRITE_FULL=0 → W_ENA=1 and APB_TX=0xA5 in the first access cycle, PREADY=1, PSLVERR=0.
- Hold WRITE_FULL=1 with WAIT_MAX=15 and write 0x3C to 0x00 → 15 wait cycles, then PREADY=1 and PSLVERR=1, W_ENA never asserted; STATUS then reads 0x05 (tx_ovf + tx_full, rx_empty=0).
- With READ_EMPTY=0 and APB_RX=0x5A, read 0x04 → R_ENA for 1 cycle, PREADY on the 2nd access cycle, PRDATA=0x5A.
- With READ_EMPTY=1, drop it to 0 after 4 wait cycles, read 0x04 → R_ENA on that cycle, completes with no error.
- Read 0x14 → immediate PSLVERR=1, PRDATA=0. Write 0x00 to CTRL, then write TXDATA → immediate PSLVERR, no W_ENA. Assert PRESETn=0 mid-wait → all outputs 0, CTRL=0x01.
- APB_BRIDGE_IRQ_EN: write CTRL=0x03, then drop READ_EMPTY → IRQ=1 one cycle later. Write 0x0C to STATUS → sticky flags clear.

Source files
------------

// File: rtl/apb_fifo_bridge_pkg.sv
// apb_fifo_bridge_pkg: register offsets, bit positions and FSM state type
// shared by the APB/FIFO bridge and its testbench.
package apb_fifo_bridge_pkg;

    // Register offsets within the 32-byte window (low 5 address bits).
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;

    // STATUS bit positions.
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;
    localparam int STAT_TX_OVF   = 2;
    localparam int STAT_RX_UDF   = 3;

    // CTRL bit positions and reset value (enabled, all interrupts masked).
    localparam int CTRL_EN    = 0;
    localparam int CTRL_M_RX  = 1;
    localparam int CTRL_M_TX  = 2;
    localparam int CTRL_M_ERR = 3;
    localparam logic [3:0] CTRL_RST = 4'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDLAT  = 2'd2
    } state_e;

    // True when the low address bits select one of the four registers.
    function automatic logic addr_mapped(input logic [4:0] a);
        logic hit;
        case (a)
            ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS, ADDR_CTRL: hit = 1'b1;
            default:                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/apb_fifo_bridge_if.sv
// apb_fifo_bridge_if: APB3 completer-side bus bundle for the FIFO bridge.
interface apb_fifo_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating wait-state counter. done is high once the
// count reaches MAX; the count then holds until cleared. MAX=0 means done
// immediately after a clear.
module apb_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic done
);
    localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] count_r;

    // Counter: clear has priority, increments stop at MAX so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == MAX_C);

endmodule

// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge: APB3 register window onto the I2C TX/RX byte FIFOs.
// Blocked FIFO accesses insert wait states up to WAIT_MAX, then end with
// PSLVERR and a sticky error flag. Define APB_BRIDGE_IRQ_EN to add the
// registered IRQ output and the writable CTRL interrupt masks.
module apb_fifo_bridge
    import apb_fifo_bridge_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_fifo_bridge_if.slave  apb,
    output logic              W_ENA,
    output logic [DATA_W-1:0] APB_TX,
    input  logic              WRITE_FULL,
    output logic              R_ENA,
    input  logic [DATA_W-1:0] APB_RX,
    input  logic              READ_EMPTY
`ifdef APB_BRIDGE_IRQ_EN
    ,
    output logic              IRQ
`endif
);

    state_e            state_r, state_nxt_s;
    logic [3:0]        ctrl_r, ctrl_nxt_s;
    logic              tx_ovf_r, rx_udf_r, tx_ovf_nxt_s, rx_udf_nxt_s;
    logic              tmr_clr_s, tmr_inc_s, tmr_done_s;
    logic              set_tx_s, set_rx_s, clr_tx_s, clr_rx_s, ctrl_wr_s;
    logic              pready_s, pslverr_s, w_ena_s, r_ena_s;
    logic [DATA_W-1:0] prdata_s, status_rd_s, ctrl_rd_s;
    logic [4:0]        addr_lo_s;
    logic              addr_ok_s, imm_err_s, en_s;
    logic              is_tx_s, is_rx_s, is_status_s;
    logic              tx_timeout_s, rx_timeout_s;
    logic              unused_pwdata_s;

    apb_wait_timer #(.MAX(WAIT_MAX)) u_wait_timer (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .clr   (tmr_clr_s),
        .inc   (tmr_inc_s),
        .done  (tmr_done_s)
    );

    assign addr_lo_s   = apb.PADDR[4:0];
    assign addr_ok_s   = ((apb.PADDR >> 5) == '0) && addr_mapped(addr_lo_s);
    assign en_s        = ctrl_r[CTRL_EN];
    assign is_tx_s     = (addr_lo_s == ADDR_TXDATA);
    assign is_rx_s     = (addr_lo_s == ADDR_RXDATA);
    assign is_status_s = (addr_lo_s == ADDR_STATUS);

    // Accesses answered with an error in the first access cycle, untouched state.
    assign imm_err_s = !addr_ok_s
                     || (is_rx_s && apb.PWRITE)
                     || (is_tx_s && !apb.PWRITE)
                     || ((is_tx_s || is_rx_s) && !en_s);

    // Timeouts set the sticky flags even if PSELx drops in the same cycle.
    assign tx_timeout_s = !imm_err_s && is_tx_s && WRITE_FULL && tmr_done_s;
    assign rx_timeout_s = !imm_err_s && is_rx_s && READ_EMPTY && tmr_done_s;

    // Only PWDATA[3:0] feeds registers; the rest is data for the TX FIFO.
    assign unused_pwdata_s = ^apb.PWDATA;

    // Read-back values for STATUS and CTRL, zero-extended to the bus width.
    always_comb begin
        status_rd_s                = '0;
        status_rd_s[STAT_TX_FULL]  = WRITE_FULL;
        status_rd_s[STAT_RX_EMPTY] = READ_EMPTY;
        status_rd_s[STAT_TX_OVF]   = tx_ovf_r;
        status_rd_s[STAT_RX_UDF]   = rx_udf_r;
        ctrl_rd_s                  = '0;
        ctrl_rd_s[3:0]             = ctrl_r;
    end

    // Transfer FSM: next state, bus response, FIFO strobes and register updates.
    always_comb begin
        state_nxt_s = state_r;
        pready_s    = 1'b0;
        pslverr_s   = 1'b0;
        prdata_s    = '0;
        w_ena_s     = 1'b0;
        r_ena_s     = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_inc_s   = 1'b0;
        set_tx_s    = 1'b0;
        set_rx_s    = 1'b0;
        clr_tx_s    = 1'b0;
        clr_rx_s    = 1'b0;
        ctrl_wr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                tmr_clr_s = 1'b1;
                if (apb.PSELx && !apb.PENABLE) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                set_tx_s = tx_timeout_s;
                set_rx_s = rx_timeout_s;
                if (!apb.PSELx) begin
                    state_nxt_s = IDLE;
                end else if (imm_err_s) begin
                    pready_s    = 1'b1;
                    pslverr_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (is_tx_s) begin
                    if (!WRITE_FULL) begin
                        w_ena_s     = 1'b1;
                        pready_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (tmr_done_s) begin
                        pready_s    = 1'b1;
                        pslverr_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        tmr_inc_s   = 1'b1;
                        state_nxt_s = ACCESS;
                    end
                end else if (is_rx_s) begin
                    if (!READ_EMPTY) begin
                        r_ena_s     = 1'b1;
                        state_nxt_s = RDLAT;
                    end else if (tmr_done_s) begin
                        pready_s    = 1'b1;
                        pslverr_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        tmr_inc_s   = 1'b1;
                        state_nxt_s = ACCESS;
                    end
                end else if (is_status_s) begin
                    pready_s    = 1'b1;
                    state_nxt_s = IDLE;
                    if (apb.PWRITE) begin
                        clr_tx_s = apb.PWDATA[STAT_TX_OVF];
                        clr_rx_s = apb.PWDATA[STAT_RX_UDF];
                    end else begin
                        prdata_s = status_rd_s;
                    end
                end else begin
                    pready_s    = 1'b1;
                    state_nxt_s = IDLE;
                    if (apb.PWRITE) begin
                        ctrl_wr_s = 1'b1;
                    end else begin
                        prdata_s = ctrl_rd_s;
                    end
                end
            end
            RDLAT: begin
                pready_s    = 1'b1;
                prdata_s    = APB_RX;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of CTRL and the sticky flags; a set beats a same-cycle clear.
    always_comb begin
        if (ctrl_wr_s) begin
`ifdef APB_BRIDGE_IRQ_EN
            ctrl_nxt_s = apb.PWDATA[3:0];
`else
            ctrl_nxt_s = {3'b000, apb.PWDATA[CTRL_EN]};
`endif
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        tx_ovf_nxt_s = (tx_ovf_r & ~clr_tx_s) | set_tx_s;
        rx_udf_nxt_s = (rx_udf_r & ~clr_rx_s) | set_rx_s;
    end

    // State, CTRL and sticky flag registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r  <= IDLE;
            ctrl_r   <= CTRL_RST;
            tx_ovf_r <= 1'b0;
            rx_udf_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            tx_ovf_r <= tx_ovf_nxt_s;
            rx_udf_r <= rx_udf_nxt_s;
        end
    end

`ifdef APB_BRIDGE_IRQ_EN
    logic irq_r;

    // Interrupt: masked FIFO-ready and error sources, registered once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (ctrl_r[CTRL_M_RX]  & ~READ_EMPTY)
                   | (ctrl_r[CTRL_M_TX]  & ~WRITE_FULL)
                   | (ctrl_r[CTRL_M_ERR] & (tx_ovf_r | rx_udf_r));
        end
    end

    assign IRQ = irq_r;
`endif

    assign apb.PREADY  = pready_s;
    assign apb.PSLVERR = pslverr_s;
    assign apb.PRDATA  = pready_s ? prdata_s : '0;
    assign W_ENA       = w_ena_s;
    assign APB_TX      = w_ena_s ? apb.PWDATA : '0;
    assign R_ENA       = r_ena_s;

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// tb_apb_fifo_bridge: directed and randomized APB transfers against a
// transaction-level model of the bridge (register map, wait-cycle rules,
// sticky flags). Build with APB_BRIDGE_IRQ_EN to also exercise IRQ.
module tb_apb_fifo_bridge;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;
    localparam int WAIT_MAX = 15;

    localparam int K_ERR = 0;
    localparam int K_TX  = 1;
    localparam int K_RX  = 2;
    localparam int K_ST  = 3;
    localparam int K_CT  = 4;

`ifdef APB_BRIDGE_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h1;
`endif

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              W_ENA, R_ENA, WRITE_FULL, READ_EMPTY;
    logic [DATA_W-1:0] APB_TX, APB_RX;
`ifdef APB_BRIDGE_IRQ_EN
    logic              IRQ;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [3:0] m_ctrl;
    logic       m_txovf, m_rxudf;

    logic [7:0] addr_tab [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h10, 8'h20, 8'h84, 8'h01};

    apb_fifo_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_fifo_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .apb        (bus),
        .W_ENA      (W_ENA),
        .APB_TX     (APB_TX),
        .WRITE_FULL (WRITE_FULL),
        .R_ENA      (R_ENA),
        .APB_RX     (APB_RX),
        .READ_EMPTY (READ_EMPTY)
`ifdef APB_BRIDGE_IRQ_EN
        ,
        .IRQ        (IRQ)
`endif
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed bundle: {PREADY, PSLVERR, W_ENA, R_ENA, PRDATA, APB_TX}.
    function automatic logic [19:0] obs();
        return {bus.PREADY, bus.PSLVERR, W_ENA, R_ENA, bus.PRDATA, APB_TX};
    endfunction

    function automatic int kind_of(input logic wr, input logic [7:0] a, input logic en);
        if (a == 8'h00) return (wr && en) ? K_TX : K_ERR;
        if (a == 8'h04) return (!wr && en) ? K_RX : K_ERR;
        if (a == 8'h08) return K_ST;
        if (a == 8'h0C) return K_CT;
        return K_ERR;
    endfunction

    // One APB transfer. The accessed FIFO is blocked for the first blk access
    // cycles; the other FIFO flag is held at oth_full / oth_empty.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input int blk, input logic oth_full, input logic oth_empty,
                        input logic [7:0] rxd, output logic [7:0] last_prd);
        int   kind, k;
        bit   done;
        logic e_rdy, e_err, e_wena, e_rena, full_k, empty_k;
        logic [7:0] e_prd, e_tx;
        kind     = kind_of(wr, addr, m_ctrl[0]);
        last_prd = 8'h00;
        @(posedge PCLK); #1;
        bus.PSELx   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = addr;
        bus.PWRITE  = wr;
        bus.PWDATA  = wd;
        APB_RX      = rxd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        done = 1'b0;
        k    = 0;
        while (!done) begin
            full_k     = (kind == K_TX) ? (k < blk) : oth_full;
            empty_k    = (kind == K_RX) ? (k < blk) : oth_empty;
            WRITE_FULL = full_k;
            READ_EMPTY = empty_k;
            e_rdy = 1'b0; e_err = 1'b0; e_wena = 1'b0; e_rena = 1'b0;
            e_prd = 8'h00; e_tx = 8'h00;
            case (kind)
                K_TX: begin
                    if (!full_k) begin e_rdy = 1'b1; e_wena = 1'b1; e_tx = wd; end
                    else if (k == WAIT_MAX) begin e_rdy = 1'b1; e_err = 1'b1; end
                end
                K_RX: begin
                    if (!empty_k) e_rena = 1'b1;
                    else if (k == WAIT_MAX) begin e_rdy = 1'b1; e_err = 1'b1; end
                end
                K_ST: begin
                    e_rdy = 1'b1;
                    if (!wr) e_prd = {4'h0, m_rxudf, m_txovf, empty_k, full_k};
                end
                K_CT: begin
                    e_rdy = 1'b1;
                    if (!wr) e_prd = {4'h0, m_ctrl};
                end
                default: begin e_rdy = 1'b1; e_err = 1'b1; end
            endcase
            @(negedge PCLK);
            chk($sformatf("acc a=%h w=%0d k=%0d", addr, wr, k), 32'(obs()),
                32'({e_rdy, e_err, e_wena, e_rena, e_prd, e_tx}));
            if (e_rdy) begin
                done     = 1'b1;
                last_prd = bus.PRDATA;
                if (kind == K_TX && e_err) m_txovf = 1'b1;
                if (kind == K_RX && e_err) m_rxudf = 1'b1;
                if (kind == K_ST && wr) begin
                    m_txovf = m_txovf & ~wd[2];
                    m_rxudf = m_rxudf & ~wd[3];
                end
                if (kind == K_CT && wr) m_ctrl = wd[3:0] & CTRL_MASK;
            end else if (e_rena) begin
                @(posedge PCLK); #1;
                @(negedge PCLK);
                chk("rdlat", 32'(obs()), 32'({4'b1000, rxd, 8'h00}));
                last_prd = bus.PRDATA;
                done     = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                k++;
            end
        end
        @(posedge PCLK); #1;
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prd, a, wd, rxd;
        logic       wr;
        int         blk;

        PRESETn     = 1'b0;
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'h00;
        bus.PWDATA  = 8'h00;
        WRITE_FULL  = 1'b0;
        READ_EMPTY  = 1'b1;
        APB_RX      = 8'h00;
        m_ctrl      = 4'h1;
        m_txovf     = 1'b0;
        m_rxudf     = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset outputs", 32'(obs()), 32'h0);
`ifdef APB_BRIDGE_IRQ_EN
        chk("reset irq", 32'(IRQ), 32'h0);
`endif
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // CTRL reset value and plain TX write.
        xfer(1'b0, 8'h0C, 8'h00, 0, 1'b0, 1'b1, 8'h00, prd);
        chk("ctrl reset", 32'(prd), 32'h01);
        xfer(1'b1, 8'h00, 8'hA5, 0, 1'b0, 1'b1, 8'h00, prd);

        // TX blocked past the limit -> timeout, then STATUS = tx_ovf | tx_full.
        xfer(1'b1, 8'h00, 8'h3C, WAIT_MAX + 5, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b0, 8'h08, 8'h00, 0, 1'b1, 1'b0, 8'h00, prd);
        chk("status after tx timeout", 32'(prd), 32'h05);

        // RX read with data ready, and RX released after 4 wait cycles.
        xfer(1'b0, 8'h04, 8'h00, 0, 1'b0, 1'b0, 8'h5A, prd);
        chk("rx data", 32'(prd), 32'h5A);
        xfer(1'b0, 8'h04, 8'h00, 4, 1'b0, 1'b0, 8'hC3, prd);
        chk("rx late data", 32'(prd), 32'hC3);

        // Release exactly at the limit completes; one later times out.
        xfer(1'b1, 8'h00, 8'h81, WAIT_MAX, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b0, 8'h04, 8'h00, WAIT_MAX + 1, 1'b0, 1'b0, 8'h99, prd);
        chk("rx timeout prdata", 32'(prd), 32'h00);
        xfer(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b1, 8'h00, prd);
        chk("status both sticky", 32'(prd), 32'h0E);
        xfer(1'b1, 8'h08, 8'h0C, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        chk("status after w1c", 32'(prd), 32'h00);

        // Immediate errors.
        xfer(1'b0, 8'h14, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        chk("unmapped prdata", 32'(prd), 32'h00);
        xfer(1'b1, 8'h04, 8'h11, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b1, 8'h84, 8'h22, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b1, 8'h0C, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b1, 8'h00, 8'h44, 0, 1'b0, 1'b0, 8'h00, prd);
        xfer(1'b0, 8'h04, 8'h00, 0, 1'b0, 1'b0, 8'h55, prd);
        xfer(1'b1, 8'h0C, 8'h01, 0, 1'b0, 1'b0, 8'h00, prd);

        // PSELx dropped mid-wait while the FIFO frees up: no strobe, no ready.
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 8'h00;
        bus.PWRITE = 1'b1; bus.PWDATA = 8'h66; WRITE_FULL = 1'b1;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus.PSELx  = 1'b0;
        WRITE_FULL = 1'b0;
        @(negedge PCLK);
        chk("psel drop", 32'(obs()), 32'h0);
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b0;
        xfer(1'b1, 8'h00, 8'h67, 0, 1'b0, 1'b0, 8'h00, prd);

        // Reset in the middle of a blocked TX write.
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 8'h00;
        bus.PWRITE = 1'b1; bus.PWDATA = 8'h77; WRITE_FULL = 1'b1;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        repeat (5) @(posedge PCLK);
        @(negedge PCLK);
        chk("waiting before reset", 32'(obs()), 32'h0);
        #1 PRESETn = 1'b0;
        #1 WRITE_FULL = 1'b0;
        #1 chk("outputs in reset", 32'(obs()), 32'h0);
        bus.PSELx   = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        m_ctrl  = 4'h1;
        m_txovf = 1'b0;
        m_rxudf = 1'b0;
        xfer(1'b0, 8'h0C, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        chk("ctrl after mid reset", 32'(prd), 32'h01);
        xfer(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b0, 8'h00, prd);
        chk("status after mid reset", 32'(prd), 32'h00);

`ifdef APB_BRIDGE_IRQ_EN
        // rx_avail mask: IRQ follows READ_EMPTY falling with one cycle lag.
        xfer(1'b1, 8'h0C, 8'h03, 0, 1'b1, 1'b1, 8'h00, prd);
        @(negedge PCLK);
        chk("irq idle", 32'(IRQ), 32'h0);
        @(posedge PCLK); #1;
        READ_EMPTY = 1'b0;
        @(negedge PCLK);
        chk("irq lag", 32'(IRQ), 32'h0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("irq rx avail", 32'(IRQ), 32'h1);
        // err mask: IRQ from a sticky flag, cleared by W1C.
        xfer(1'b1, 8'h0C, 8'h09, 0, 1'b1, 1'b1, 8'h00, prd);
        xfer(1'b1, 8'h00, 8'h12, WAIT_MAX + 2, 1'b1, 1'b1, 8'h00, prd);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("irq err", 32'(IRQ), 32'h1);
        xfer(1'b1, 8'h08, 8'h0C, 0, 1'b1, 1'b1, 8'h00, prd);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("irq after w1c", 32'(IRQ), 32'h0);
        xfer(1'b1, 8'h0C, 8'h01, 0, 1'b1, 1'b1, 8'h00, prd);
`endif

        // Randomized transfers.
        for (int i = 0; i < 250; i++) begin
            a   = addr_tab[$urandom_range(0, 8)];
            wr  = 1'($urandom_range(0, 1));
            wd  = 8'($urandom);
            rxd = 8'($urandom);
            if (a == 8'h0C) wd[0] = ($urandom_range(0, 3) != 0);
            blk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_MAX + 2) : 0;
            xfer(wr, a, wd, blk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rxd, prd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
